phase_marker_emitter: RTL and testbench

Producer side of the phase-marker protocol: turns phase start/end requests from the stimulus sequencer into the 32-bit marker instruction words (`slti x0, x0, code`) that the ROB-commit monitors decode into VCTM/DELAY/TEXE/LEAK/INIT/BIM/TRAIN/SIM_EXIT events. It sits between the testcase sequencer and the instruction-injection port of the DUT fetch path. It buffers markers in a small FIFO and enforces start/end pairing. On exit it auto-closes open phases, and it reproduces the post-window countdown (`tsx_done`) that the monitor side uses.

---
 rtl/phase_marker_emitter.sv | 217 +++++++++++++++++++++
 tb/tb_phase_marker_emitter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_marker_emitter.sv
// phase_marker_emitter
// Turns phase start/end requests into "slti x0, x0, code" marker words,
// buffers them in a small FIFO, enforces start/end pairing, auto-closes
// open phases on EXIT and produces the post-window tsx_done countdown.
//
// Handshake rule (both sides): a transfer happens on the rising clock edge
// where valid and ready are both high; valid never depends on ready, and
// req_ready never depends on req_valid.
module phase_marker_emitter #(
  parameter int DEPTH   = 4,
  parameter int TSX_LAT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_phase,
  input  logic        req_end,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_bits,
  output logic [7:0]  inst_seq,
  output logic [6:0]  open_mask,
  output logic        err,
  output logic [3:0]  err_code,
  output logic        tsx_done,
  output logic        done,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [3:0]  L_EXIT_CODE = 4'hE;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic [31:0]        r_hold_bits;
  logic [7:0]         r_seq;
  logic [6:0]         r_mask;
  logic               r_err;
  logic [3:0]         r_err_code;
  logic [TSX_LAT-1:0] r_tsx_sr;
  logic               r_tsx_done;
  logic               r_done;

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic [3:0]         w_push_code;
  logic [6:0]         w_mask_next;
  logic               w_req_ready;
  logic               w_set_err;
  logic [3:0]         w_err_code_in;
  logic [3:0]         w_head_code;
  logic [31:0]        w_head_bits;
  logic [7:0]         w_req_onehot8;
  logic [6:0]         w_req_onehot;
  logic [2:0]         w_low_idx;
  logic               w_tsx_qual;

  assign w_full        = (r_count == L_FULL);
  assign w_empty       = (r_count == '0);
  assign w_pop         = !w_empty && inst_ready;
  assign w_head_code   = r_mem[r_rd_ptr];
  assign w_head_bits   = {8'h00, w_head_code, 20'h02013};
  assign w_req_onehot8 = 8'd1 << req_phase;
  assign w_req_onehot  = w_req_onehot8[6:0];

  // Lowest-numbered open phase, used by FLUSH to close phases in order.
  always_comb begin
    w_low_idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (r_mask[i]) w_low_idx = 3'(i);
    end
  end

  // Next-state, request acceptance, pairing checks and FIFO push selection.
  always_comb begin
    w_state_next  = r_state;
    w_push        = 1'b0;
    w_push_code   = 4'h0;
    w_mask_next   = r_mask;
    w_req_ready   = 1'b0;
    w_set_err     = 1'b0;
    w_err_code_in = 4'h0;
    case (r_state)
      ST_RUN: begin
        w_req_ready = reset && !w_full;
        if (req_valid && w_req_ready) begin
          if (req_phase == 3'd7) begin
            w_state_next = ST_FLUSH;
          end else if (!req_end && ((r_mask & w_req_onehot) == '0)) begin
            w_push      = 1'b1;
            w_push_code = {req_phase, 1'b0};
            w_mask_next = r_mask | w_req_onehot;
          end else if (req_end && ((r_mask & w_req_onehot) != '0)) begin
            w_push      = 1'b1;
            w_push_code = {req_phase, 1'b1};
            w_mask_next = r_mask & ~w_req_onehot;
          end else begin
            w_set_err     = 1'b1;
            w_err_code_in = {req_phase, req_end};
          end
        end
      end
      ST_FLUSH: begin
        if (!w_full) begin
          w_push = 1'b1;
          if (r_mask != '0) begin
            w_push_code = {w_low_idx, 1'b1};
            w_mask_next = r_mask & ~(7'd1 << w_low_idx);
          end else begin
            w_push_code  = L_EXIT_CODE;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_req_ready = 1'b0;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State register, open-phase mask and sticky error capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_mask     <= '0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      if (w_set_err) begin
        r_err <= 1'b1;
        if (!r_err) r_err_code <= w_err_code_in;
      end
    end
  end

  // Marker storage; contents are only meaningful between rd and wr pointers.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_code;
  end

  // FIFO pointers, occupancy, held output word and output sequence index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hold_bits <= '0;
      r_seq       <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_hold_bits <= w_head_bits;
        r_seq       <= r_seq + 8'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A VCTM_END or TEXE_START handshake starts the countdown once only.
  assign w_tsx_qual = w_pop && ((w_head_code == 4'h1) || (w_head_code == 4'h4))
                      && !r_tsx_done && (r_tsx_sr == '0);

  // tsx one-hot countdown and the done flag after SIM_EXIT leaves.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tsx_sr   <= '0;
      r_tsx_done <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_tsx_qual) begin
        r_tsx_sr <= TSX_LAT'(1);
      end else if (r_tsx_sr[TSX_LAT-1]) begin
        r_tsx_sr   <= '0;
        r_tsx_done <= 1'b1;
      end else begin
        r_tsx_sr <= r_tsx_sr << 1;
      end
      if (w_pop && (w_head_code == L_EXIT_CODE)) r_done <= 1'b1;
    end
  end

  assign req_ready  = w_req_ready;
  assign inst_valid = !w_empty;
  assign inst_bits  = w_empty ? r_hold_bits : w_head_bits;
  assign inst_seq   = r_seq;
  assign open_mask  = r_mask;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign tsx_done   = r_tsx_done;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_phase_marker_emitter.sv
// Directed bench for phase_marker_emitter: reset values, pairing, backpressure,
// error capture, EXIT auto-close, tsx countdown and reset during FLUSH.
module tb_phase_marker_emitter;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_phase;
  logic        req_end;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_bits;
  logic [7:0]  inst_seq;
  logic [6:0]  open_mask;
  logic        err;
  logic [3:0]  err_code;
  logic        tsx_done;
  logic        done;
  logic [1:0]  dbg_state;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] got_q[$];
  logic [7:0]  gseq_q[$];
  logic [31:0] exp_q[$];

  phase_marker_emitter #(.DEPTH(4), .TSX_LAT(3)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_phase(req_phase), .req_end(req_end),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_bits(inst_bits), .inst_seq(inst_seq),
    .open_mask(open_mask), .err(err), .err_code(err_code),
    .tsx_done(tsx_done), .done(done), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output monitor: inputs change only just after posedge, so a word seen
  // valid&ready at negedge is the one handshaken on the next posedge.
  always @(negedge clock) begin
    if (reset === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      got_q.push_back(inst_bits);
      gseq_q.push_back(inst_seq);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    got_q.delete(); gseq_q.delete(); exp_q.delete();
  endtask

  task automatic send_req(input logic [2:0] p, input logic e);
    int k;
    req_phase = p; req_end = e; req_valid = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      tick(); k++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_req_timeout phase=%0d: req_ready=%b required 1", p, req_ready);
    end else begin
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 100) begin
      tick(); k++;
    end
    n_cmp++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL wait_words: got %0d words required %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; inst_ready = 1'b0; req_phase = 3'd0; req_end = 1'b0;
    tick(); tick();
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_low: got %b required 0", req_ready);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_high: got %b required 1", req_ready);
    end
    n_cmp++;
    if ({inst_valid, inst_bits, inst_seq, open_mask, err, err_code, tsx_done, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b bits=%h seq=%0d mask=%h err=%b code=%h tsx=%b done=%b required all 0",
               inst_valid, inst_bits, inst_seq, open_mask, err, err_code, tsx_done, done);
    end
    n_cmp++;
    if (dbg_state !== S_RUN) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", dbg_state, S_RUN);
    end
  endtask

  task automatic test_init_pair();
    inst_ready = 1'b1;
    send_req(3'd4, 1'b0);
    n_cmp++;
    if (open_mask !== 7'h10 || inst_valid !== 1'b1 || inst_bits !== 32'h00802013 || inst_seq !== 8'd0) begin
      n_fail++;
      $display("FAIL init_start: mask=%h valid=%b bits=%h seq=%0d required 10 1 00802013 0",
               open_mask, inst_valid, inst_bits, inst_seq);
    end
    send_req(3'd4, 1'b1);
    n_cmp++;
    if (open_mask !== 7'h00 || inst_bits !== 32'h00902013 || inst_seq !== 8'd1) begin
      n_fail++;
      $display("FAIL init_end: mask=%h bits=%h seq=%0d required 00 00902013 1", open_mask, inst_bits, inst_seq);
    end
    tick();
    n_cmp++;
    if (inst_valid !== 1'b0 || inst_seq !== 8'd2) begin
      n_fail++; $display("FAIL init_drained: valid=%b seq=%0d required 0 2", inst_valid, inst_seq);
    end
    exp_q = '{32'h00802013, 32'h00902013};
    n_cmp++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL init_count: got %0d words required 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL init_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] ph [5];
    int k;
    ph = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd6};
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_req(ph[i], 1'b0);
    req_phase = ph[4]; req_end = 1'b0; req_valid = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0 || open_mask !== 7'h2B) begin
      n_fail++; $display("FAIL bp_full: ready=%b mask=%h required 0 2b", req_ready, open_mask);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (req_ready !== 1'b0 || inst_bits !== 32'h00002013 || inst_seq !== 8'd0) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b bits=%h seq=%0d required 0 00002013 0", req_ready, inst_bits, inst_seq);
    end
    inst_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full_with_pop: ready=%b required 0", req_ready);
    end
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || got_q.size() != 1) begin
      n_fail++; $display("FAIL bp_reopen: ready=%b words=%0d required 1 1", req_ready, got_q.size());
    end
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (open_mask !== 7'h6B) begin
      n_fail++; $display("FAIL bp_fifth_mask: got %h required 6b", open_mask);
    end
    wait_words(5);
    k = 0;
    exp_q = '{32'h00002013, 32'h00202013, 32'h00602013, 32'h00A02013, 32'h00C02013};
    if (got_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i] || gseq_q[i] !== 8'(i)) begin
          n_fail++;
          $display("FAIL bp_word%0d: got %h seq %0d required %h seq %0d", i, got_q[i], gseq_q[i], exp_q[i], i);
        end
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    inst_ready = 1'b0;
    send_req(3'd1, 1'b1);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 4'h3 || inst_valid !== 1'b0 || open_mask !== 7'h00) begin
      n_fail++;
      $display("FAIL err_delay_end: err=%b code=%h valid=%b mask=%h required 1 3 0 00",
               err, err_code, inst_valid, open_mask);
    end
    send_req(3'd6, 1'b0);
    send_req(3'd6, 1'b0);
    n_cmp++;
    if (err !== 1'b1 || err_code !== 4'h3 || open_mask !== 7'h40) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b code=%h mask=%h required 1 3 40", err, err_code, open_mask);
    end
    inst_ready = 1'b1;
    wait_words(1);
    tick(); tick(); tick();
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 32'h00C02013) begin
      n_fail++;
      $display("FAIL err_words: count=%0d first=%h required 1 00c02013", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 32'h0);
    end
  endtask

  task automatic test_exit_flush();
    int k;
    do_reset();
    inst_ready = 1'b1;
    send_req(3'd0, 1'b0);
    send_req(3'd3, 1'b0);
    wait_words(2);
    got_q.delete(); gseq_q.delete();
    send_req(3'd7, 1'b0);
    n_cmp++;
    if (dbg_state !== S_FLUSH || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL exit_flush_state: state=%0d ready=%b required 1 0", dbg_state, req_ready);
    end
    k = 0;
    while (!(inst_valid === 1'b1 && inst_bits === 32'h00E02013) && k < 50) begin
      tick(); k++;
    end
    n_cmp++;
    if (done !== 1'b0 || inst_bits !== 32'h00E02013) begin
      n_fail++; $display("FAIL exit_before_done: done=%b bits=%h required 0 00e02013", done, inst_bits);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || req_ready !== 1'b0 || dbg_state !== S_DONE || inst_valid !== 1'b0 || open_mask !== 7'h0) begin
      n_fail++;
      $display("FAIL exit_done: done=%b ready=%b state=%0d valid=%b mask=%h required 1 0 2 0 00",
               done, req_ready, dbg_state, inst_valid, open_mask);
    end
    exp_q = '{32'h00102013, 32'h00702013, 32'h00E02013};
    n_cmp++;
    if (got_q.size() != 3) begin
      n_fail++; $display("FAIL exit_count: got %0d words required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL exit_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_tsx();
    logic exp_t;
    do_reset();
    inst_ready = 1'b0;
    send_req(3'd0, 1'b0);
    send_req(3'd2, 1'b0);
    send_req(3'd0, 1'b1);
    inst_ready = 1'b1;
    // Edge 1 pops VCTM_START, edge 2 TEXE_START (N), edge 3 VCTM_END (N+1).
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_t = (i >= 5);
      n_cmp++;
      if (tsx_done !== exp_t) begin
        n_fail++; $display("FAIL tsx_edge%0d: got %b required %b", i, tsx_done, exp_t);
      end
    end
    n_cmp++;
    if (got_q.size() != 3 || got_q[1] !== 32'h00402013 || got_q[2] !== 32'h00102013) begin
      n_fail++; $display("FAIL tsx_order: count=%0d required 3 with 00402013 then 00102013", got_q.size());
    end
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    inst_ready = 1'b1;
    send_req(3'd1, 1'b0);
    send_req(3'd3, 1'b0);
    send_req(3'd5, 1'b0);
    wait_words(3);
    inst_ready = 1'b0;
    send_req(3'd7, 1'b0);
    tick(); tick();
    n_cmp++;
    if (dbg_state !== S_FLUSH || open_mask !== 7'h20 || inst_valid !== 1'b1 ||
        inst_bits !== 32'h00302013 || inst_seq !== 8'd3) begin
      n_fail++;
      $display("FAIL flush_mid: state=%0d mask=%h valid=%b bits=%h seq=%0d required 1 20 1 00302013 3",
               dbg_state, open_mask, inst_valid, inst_bits, inst_seq);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (inst_valid !== 1'b0 || open_mask !== 7'h0 || dbg_state !== S_RUN || inst_seq !== 8'd0 ||
        req_ready !== 1'b0 || inst_bits !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_reset: valid=%b mask=%h state=%0d seq=%0d ready=%b bits=%h required 0 00 0 0 0 0",
               inst_valid, open_mask, dbg_state, inst_seq, req_ready, inst_bits);
    end
    reset = 1'b1;
    #1;
    tick(); tick();
    n_cmp++;
    if (req_ready !== 1'b1 || inst_valid !== 1'b0 || dbg_state !== S_RUN) begin
      n_fail++;
      $display("FAIL flush_after_reset: ready=%b valid=%b state=%0d required 1 0 0", req_ready, inst_valid, dbg_state);
    end
  endtask

  // Sequence of scenarios and final report
  initial begin
    test_reset();
    test_init_pair();
    test_backpressure();
    test_error();
    test_exit_flush();
    test_tsx();
    test_reset_in_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
